uart_tx_io: RTL
===============

UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter BASE_ADR, default 16'h6000: base of the 4-byte register window BASE_ADR..BASE_ADR+3.
REQ-002 Parameter CLK_DIV, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-003 Port clk, input, 1 bit: the single clock. Bus writes, bus reads and TX logic all act on posedge clk; the CPU drives the bus on negedge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port adr_bus, input, 16 bits: CPU address bus.
REQ-006 Port cpu_data, input, 8 bits: CPU write data, which is the CPU data_bus_out.
REQ-007 Port RW, input, 1 bit: 1 = read, 0 = write.
REQ-008 Port sel, output, 1 bit: combinational; high when adr_bus[15:2] == BASE_ADR[15:2]. Drives the external read mux.
REQ-009 Port data_out, output, 8 bits: registered read data that feeds the CPU data_bus_in.
REQ-010 Port tx, output, 1 bit: serial line, idle high.
REQ-011 Port dbg_fifo_count, output, 3 bits: FIFO occupancy, range 0..4.

Function
REQ-012 Register map is selected by adr_bus[1:0]:
- 0 = DATA. A write pushes to the FIFO; a read returns 8'h00.
- 1 = STATUS, read only. bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky); bits 7:4 read 0. Any write clears overflow.
- 2 = CTRL. bit0 tx_en; other bits write-ignored and read 0.
- 3 = reserved. Reads return 8'h00; writes are ignored.
REQ-013 Each posedge with sel=1 and RW=0 SHALL perform exactly one register write; RW held low for N posedges produces N writes.
REQ-014 At each posedge with sel=1, data_out SHALL load the register selected by adr_bus[1:0]; with sel=0, data_out SHALL hold its value. Read data is therefore valid at the following negedge.
REQ-015 Reads SHALL have no side effects.
REQ-016 The FIFO SHALL be 4 entries deep, with 2-bit read and write pointers wrapping 3->0 and a 3-bit count.
REQ-017 A push SHALL be accepted when count<4, or when count==4 and a pop occurs on the same edge.
REQ-018 A push that is not accepted SHALL drop the byte, leave the FIFO unchanged and set overflow.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and preserve byte order.
REQ-020 If an overflow-clearing STATUS write coincides with a new overflow event, overflow SHALL end set.
REQ-021 TX FSM states are IDLE, START, DATA, STOP. A baud counter counts CLK_DIV cycles per bit and a 3-bit bit index selects the data bit.
REQ-022 IDLE: tx=1. On a posedge with tx_en=1 and count>0, pop the head into the shift register and go to START.
REQ-023 START: tx=0 for CLK_DIV cycles, then go to DATA.
REQ-024 DATA: 8 bits, LSB first, each held CLK_DIV cycles, then go to STOP.
REQ-025 STOP: tx=1 for CLK_DIV cycles. At the end of STOP:
- if tx_en=1 and count>0, pop and go directly to START, with no idle gap;
- otherwise go to IDLE.
REQ-026 Frame length SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL have a period of exactly 10*CLK_DIV cycles.
REQ-027 A byte pushed on posedge k into an empty FIFO while IDLE and tx_en=1 SHALL drive tx low after posedge k+1.
REQ-028 Clearing tx_en mid-frame SHALL let the current frame complete; no new pop occurs until tx_en=1.
REQ-029 tx SHALL be registered and glitch-free.

Reset
REQ-030 While reset=1, independent of clk:
- FIFO pointers and count = 0; FIFO storage contents are don't-care.
- overflow = 0, tx_en = 1.
- FSM = IDLE, baud counter and bit index = 0, tx = 1.
- data_out = 8'h00.
REQ-031 Reset asserted mid-frame SHALL abort the frame: tx goes high immediately and queued bytes are discarded.
REQ-032 After reset deasserts, the first posedge SHALL operate normally.

Verification (CLK_DIV=4, BASE_ADR=16'h6000)
REQ-033 Write 8'hA5 to 6000 -> tx low one posedge later. The line then carries 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB first, stop), each bit 4 cycles, 40 cycles total. STATUS busy=1 during the frame and empty=1 after the pop.
REQ-034 Write 6 bytes 01..06 back-to-back with tx_en=0 -> count 4, full=1, overflow=1 after byte 5. Set tx_en=1 -> bytes 01,02,03,04 transmitted contiguously at a 40-cycle period; 05 and 06 are never sent.
REQ-035 Read 6001 with an empty FIFO, not busy -> data_out=8'h02 at the next negedge. Write any value to 6001 after an overflow -> the next read returns bit3=0.
REQ-036 FIFO full, and a push coincides with an end-of-STOP pop -> push accepted, overflow stays 0, byte order preserved.
REQ-037 Assert reset in the middle of the DATA state with 2 bytes queued -> tx=1 at once, count=0. Deassert and write 8'h3C -> only 3C is transmitted, as a clean frame.
REQ-038 Access 6003 (read and write) and 6004 -> data_out=8'h00 for the 6003 read. sel=0 at 6004 and data_out holds its value. No state change occurs.

Source files
------------

// File: rtl/uart_tx_io.sv
// uart_tx_io
// Memory-mapped UART transmitter with a 4-entry byte FIFO.
//
// The CPU sees a 4-byte register window at BASE_ADR..BASE_ADR+3:
//   +0 DATA   write pushes a byte into the FIFO, read returns 8'h00
//   +1 STATUS read only: bit0 full, bit1 empty, bit2 busy, bit3 overflow
//             (sticky); any write clears overflow
//   +2 CTRL   bit0 tx_en (other bits ignored, read 0)
//   +3 reserved, reads 8'h00, writes ignored
//
// Ports:
//   clk            single clock; bus and TX logic act on its rising edge
//   reset          asynchronous, active-high reset
//   adr_bus        CPU address bus
//   cpu_data       CPU write data
//   RW             1 = read, 0 = write
//   sel            combinational window decode, drives the external read mux
//   data_out       registered read data for the CPU data_bus_in
//   tx             serial output, idle high (8N1, LSB first)
//   dbg_fifo_count FIFO occupancy 0..4
//
// Parameters:
//   BASE_ADR  base address of the register window (low two bits ignored)
//   CLK_DIV   clock cycles per serial bit, 2..65535

module uart_tx_io #(
  parameter logic [15:0] BASE_ADR = 16'h6000,
  parameter int          CLK_DIV  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adr_bus,
  input  logic [7:0]  cpu_data,
  input  logic        RW,
  output logic        sel,
  output logic [7:0]  data_out,
  output logic        tx,
  output logic [2:0]  dbg_fifo_count
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Register-window decode
  logic       wr_en;
  logic       wr_data_reg;
  logic       wr_status_reg;
  logic       wr_ctrl_reg;

  // FIFO
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_pop;
  logic       push_ok;
  logic [7:0] fifo_head;

  // Control / status
  logic       overflow_q, overflow_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] status_byte;

  // Transmitter
  state_t     state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       baud_done;
  logic       busy;
  logic [2:0] next_bit_idx;

  assign sel            = (adr_bus[15:2] == BASE_ADR[15:2]);
  assign data_out       = data_out_q;
  assign tx             = tx_q;
  assign dbg_fifo_count = count_q;

  // Every edge with the window selected and RW low is one register write,
  // so holding RW low for several cycles yields several writes.
  assign wr_en         = sel & ~RW;
  assign wr_data_reg   = wr_en & (adr_bus[1:0] == 2'd0);
  assign wr_status_reg = wr_en & (adr_bus[1:0] == 2'd1);
  assign wr_ctrl_reg   = wr_en & (adr_bus[1:0] == 2'd2);

  assign fifo_empty   = (count_q == 3'd0);
  assign fifo_full    = (count_q == 3'd4);
  assign fifo_head    = fifo_mem[rd_ptr_q];
  assign busy         = (state_q != ST_IDLE);
  assign baud_done    = (baud_q == BAUD_LAST);
  assign next_bit_idx = bit_idx_q + 3'd1;
  assign status_byte  = {4'b0000, overflow_q, busy, fifo_empty, fifo_full};

  // Transmit sequencing. tx_d is the value the line takes after this edge,
  // so the line comes straight from a flop and never glitches. A pop at the
  // end of STOP jumps straight back into START, giving back-to-back frames
  // with no idle gap.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          state_d   = ST_START;
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
        end
      end

      ST_START: begin
        if (baud_done) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit_idx;
            tx_d      = shift_q[next_bit_idx];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      ST_STOP: begin
        if (baud_done) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          if (tx_en_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        baud_d    = 16'd0;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping. A push into a full FIFO still succeeds when the
  // transmitter pops on the same edge; the slot being written is the one
  // being read, and the read sees the old contents, so order is preserved.
  always_comb begin
    push_ok  = wr_data_reg && (!fifo_full || fifo_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    case ({push_ok, fifo_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control register and sticky overflow. The set term comes last so a
  // rejected push wins over a clear on the same edge.
  always_comb begin
    tx_en_d    = tx_en_q;
    overflow_d = overflow_q;

    if (wr_ctrl_reg) begin
      tx_en_d = cpu_data[0];
    end
    if (wr_status_reg) begin
      overflow_d = 1'b0;
    end
    if (wr_data_reg && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // Read data is captured on every selected edge, regardless of RW, and
  // simply holds when the window is not selected. Reads never alter state.
  always_comb begin
    data_out_d = data_out_q;
    if (sel) begin
      case (adr_bus[1:0])
        2'd0:    data_out_d = 8'h00;
        2'd1:    data_out_d = status_byte;
        2'd2:    data_out_d = {7'b0000000, tx_en_q};
        default: data_out_d = 8'h00;
      endcase
    end
  end

  // FIFO storage has no reset; its contents are meaningless while the
  // pointers say the slots are empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= cpu_data;
    end
  end

  // All control state. Reset aborts any frame in flight, drops queued
  // bytes and forces the line high without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b1;
      data_out_q <= 8'h00;
      state_q    <= ST_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_en_q    <= tx_en_d;
      data_out_q <= data_out_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
